// File: rtl/piso_serializer.sv
// ============================================================================
//  Module   : piso_serializer
//  Purpose  : Parallel-in/serial-out stage with a one-word holding buffer so
//             back-to-back words stream with no idle bit in between.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             last_bit
);

    localparam int            CNT_W      = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(WIDTH - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]       state_q,     state_d;
    logic [WIDTH-1:0] shift_reg_q, shift_reg_d;
    logic [CNT_W-1:0] bit_cnt_q,   bit_cnt_d;
    logic [WIDTH-1:0] hold_reg_q,  hold_reg_d;
    logic             hold_full_q, hold_full_d;

    logic             w_accept;
    logic             w_word_end;
    logic             w_head_bit;
    logic [WIDTH-1:0] w_shifted;

    // The output end of the shift register depends on bit order.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_head_bit = shift_reg_q[WIDTH-1];
            assign w_shifted  = {shift_reg_q[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_head_bit = shift_reg_q[0];
            assign w_shifted  = {1'b0, shift_reg_q[WIDTH-1:1]};
        end
    endgenerate

    assign w_accept   = load_valid && !hold_full_q;
    assign w_word_end = shift_en && (bit_cnt_q == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            shift_reg_q <= '0;
            bit_cnt_q   <= '0;
            hold_reg_q  <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_reg_q <= shift_reg_d;
            bit_cnt_q   <= bit_cnt_d;
            hold_reg_q  <= hold_reg_d;
            hold_full_q <= hold_full_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_reg_d = shift_reg_q;
        bit_cnt_d   = bit_cnt_q;
        hold_reg_d  = hold_reg_q;
        hold_full_d = hold_full_q;

        case (state_q)
            ST_IDLE: begin
                if (hold_full_q) begin
                    shift_reg_d = hold_reg_q;
                    bit_cnt_d   = c_LAST_CNT;
                    hold_full_d = 1'b0;
                    state_d     = ST_SHIFT;
                end else if (w_accept) begin
                    shift_reg_d = data_in;
                    bit_cnt_d   = c_LAST_CNT;
                    state_d     = ST_SHIFT;
                end
            end
            default: begin
                if (w_word_end) begin
                    // Reload from hold first so acceptance order is kept.
                    if (hold_full_q) begin
                        shift_reg_d = hold_reg_q;
                        bit_cnt_d   = c_LAST_CNT;
                        hold_full_d = 1'b0;
                    end else if (w_accept) begin
                        shift_reg_d = data_in;
                        bit_cnt_d   = c_LAST_CNT;
                    end else begin
                        state_d     = ST_IDLE;
                    end
                end else begin
                    if (shift_en) begin
                        shift_reg_d = w_shifted;
                        bit_cnt_d   = bit_cnt_q - CNT_W'(1);
                    end
                    if (w_accept) begin
                        hold_reg_d  = data_in;
                        hold_full_d = 1'b1;
                    end
                end
            end
        endcase
    end

    always_comb begin
        load_ready = !hold_full_q;
        ser_valid  = (state_q == ST_SHIFT);
        ser_out    = (state_q == ST_SHIFT) ? w_head_bit : 1'b0;
        last_bit   = (state_q == ST_SHIFT) && (bit_cnt_q == '0);
    end

endmodule

`default_nettype wire

// File: tb/tb_piso_serializer.sv
// ============================================================================
//  Module   : tb_piso_serializer
//  Purpose  : Self-checking bench for piso_serializer (MSB-first and LSB-first
//             instances driven in parallel against a bit-queue scoreboard).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_piso_serializer;

    localparam int W = 8;

    typedef struct packed {
        logic b;
        logic last;
    } sbit_t;

    logic         clock;
    logic         reset;
    logic [W-1:0] data_in;
    logic         load_valid;
    logic         shift_en;

    logic ready_m, out_m, valid_m, last_m;
    logic ready_l, out_l, valid_l, last_l;

    sbit_t qm[$];
    sbit_t ql[$];

    int   errors = 0;
    int   checks = 0;

    logic [2:0] det_hist;
    int         det_bits;
    int         det_cnt;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
        .clock      (clock),
        .reset      (reset),
        .data_in    (data_in),
        .load_valid (load_valid),
        .load_ready (ready_m),
        .shift_en   (shift_en),
        .ser_out    (out_m),
        .ser_valid  (valid_m),
        .last_bit   (last_m)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
        .clock      (clock),
        .reset      (reset),
        .data_in    (data_in),
        .load_valid (load_valid),
        .load_ready (ready_l),
        .shift_en   (shift_en),
        .ser_out    (out_l),
        .ser_valid  (valid_l),
        .last_bit   (last_l)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare both instances against the head of their bit queues.
    task automatic compare();
        logic ev, eo, el, er;
        ev = (qm.size() > 0);
        eo = ev ? qm[0].b    : 1'b0;
        el = ev ? qm[0].last : 1'b0;
        er = (qm.size() <= W);
        chk("msb_ser_valid",  valid_m, ev);
        chk("msb_ser_out",    out_m,   eo);
        chk("msb_last_bit",   last_m,  el);
        chk("msb_load_ready", ready_m, er);
        ev = (ql.size() > 0);
        eo = ev ? ql[0].b    : 1'b0;
        el = ev ? ql[0].last : 1'b0;
        er = (ql.size() <= W);
        chk("lsb_ser_valid",  valid_l, ev);
        chk("lsb_ser_out",    out_l,   eo);
        chk("lsb_last_bit",   last_l,  el);
        chk("lsb_load_ready", ready_l, er);
        if (valid_m === 1'b1) begin
            det_hist = {det_hist[1:0], out_m};
            det_bits++;
            if (det_bits >= 3 && det_hist == 3'b101) det_cnt++;
        end
    endtask

    // Drive one cycle of inputs, update the scoreboard, then check outputs.
    task automatic step(input logic r, input logic lv, input logic [W-1:0] d,
                        input logic se);
        logic acc;
        reset      = r;
        load_valid = lv;
        data_in    = d;
        shift_en   = se;
        if (r) begin
            qm.delete();
            ql.delete();
        end else begin
            acc = lv && (qm.size() <= W);
            if (se && qm.size() > 0) void'(qm.pop_front());
            if (se && ql.size() > 0) void'(ql.pop_front());
            if (acc) begin
                for (int i = 0; i < W; i++) begin
                    qm.push_back('{b: d[W-1-i], last: (i == W-1)});
                    ql.push_back('{b: d[i],     last: (i == W-1)});
                end
            end
        end
        @(posedge clock);
        @(negedge clock);
        compare();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b1);
    endtask

    initial begin
        reset      = 1'b1;
        load_valid = 1'b0;
        data_in    = '0;
        shift_en   = 1'b0;
        det_hist   = '0;
        det_bits   = 0;
        det_cnt    = 0;
        @(negedge clock);

        // Reset state
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 8'hFF, 1'b1);

        // Single word
        step(1'b0, 1'b1, 8'hA5, 1'b1);
        idle(10);

        // Back-to-back words through the holding buffer
        step(1'b0, 1'b1, 8'hF0, 1'b1);
        step(1'b0, 1'b1, 8'h0F, 1'b1);
        for (int t = 2; t <= 8; t++) step(1'b0, 1'b1, 8'h55, 1'b1);
        idle(10);

        // Stall in the middle of a word
        step(1'b0, 1'b1, 8'hA5, 1'b1);
        for (int t = 1; t <= 12; t++) step(1'b0, 1'b0, 8'h00, !(t >= 3 && t <= 5));

        // Single-bit word exercises bit order on both instances
        step(1'b0, 1'b1, 8'h01, 1'b1);
        idle(10);

        // Reset mid-word with a word held
        step(1'b0, 1'b1, 8'hA5, 1'b1);
        step(1'b0, 1'b1, 8'h3C, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b1, 8'hFF, 1'b1);
        step(1'b0, 1'b1, 8'h80, 1'b1);
        idle(10);

        // Serial stream of 0xAA fed to a "101" overlapping detector model
        det_hist = '0;
        det_bits = 0;
        det_cnt  = 0;
        step(1'b0, 1'b1, 8'hAA, 1'b1);
        idle(9);
        checks++;
        assert (det_cnt === 3)
        else begin
            errors++;
            $error("FAIL det_pulses observed=%0d expected=3", det_cnt);
        end

        // Random traffic with random stalls, then drain
        for (int i = 0; i < 120; i++)
            step(1'b0, 1'($urandom_range(0, 1)), W'($urandom),
                 ($urandom_range(0, 3) != 0));
        idle(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
